// File: rtl/nvdla_sdp_wdma_cmd.sv
// nvdla_sdp_wdma_cmd: walks the programmed output cube one line at a time.
// For each line it issues a DMA command and a split command on two
// independent valid/ready channels. The walk advances only after both
// channels have accepted the current line.
module nvdla_sdp_wdma_cmd #(
    parameter int AW = 60,
    parameter int SW = 13
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic                op_load,
    input  logic [SW-1:0]       reg2dp_width,
    input  logic [12:0]         reg2dp_height,
    input  logic [7:0]          reg2dp_surf_num,
    input  logic [AW-1:0]       reg2dp_dst_base_addr,
    input  logic [27:0]         reg2dp_dst_line_stride,
    input  logic [27:0]         reg2dp_dst_surf_stride,
    output logic                cmd2dat_dma_pvld,
    input  logic                cmd2dat_dma_prdy,
    output logic [AW+SW+1:0]    cmd2dat_dma_pd,
    output logic                cmd2dat_spt_pvld,
    input  logic                cmd2dat_spt_prdy,
    output logic [SW+1:0]       cmd2dat_spt_pd,
    output logic                cmd_busy,
    output logic                cmd_done
);

    localparam int DPW = AW + SW + 2;
    localparam int SPW = SW + 2;
    localparam int STW = 28;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;

    // Layer parameters latched at op_load so register writes during RUN are harmless
    logic [SW-1:0]   width_q, width_d;
    logic [12:0]     height_q, height_d;
    logic [7:0]      surf_num_q, surf_num_d;
    logic [STW-1:0]  line_stride_q, line_stride_d;
    logic [STW-1:0]  surf_stride_q, surf_stride_d;

    // Walk position
    logic [12:0]     line_cnt_q, line_cnt_d;
    logic [7:0]      surf_cnt_q, surf_cnt_d;
    logic [AW-1:0]   line_addr_q, line_addr_d;
    logic [AW-1:0]   surf_addr_q, surf_addr_d;

    // Per-channel "already accepted this line" flags
    logic            dma_acc_q, dma_acc_d;
    logic            spt_acc_q, spt_acc_d;

    // Registered channel outputs
    logic            dma_pvld_q, dma_pvld_d;
    logic            spt_pvld_q, spt_pvld_d;
    logic [DPW-1:0]  dma_pd_q, dma_pd_d;
    logic [SPW-1:0]  spt_pd_q, spt_pd_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic            dma_fire;
    logic            spt_fire;
    logic            pair_done;
    logic            cur_cube_end;
    logic [AW-1:0]   line_stride_ext;
    logic [AW-1:0]   surf_stride_ext;

    assign dma_fire        = dma_pvld_q & cmd2dat_dma_prdy;
    assign spt_fire        = spt_pvld_q & cmd2dat_spt_prdy;
    assign pair_done       = (dma_acc_q | dma_fire) & (spt_acc_q | spt_fire);
    assign cur_cube_end    = (line_cnt_q == height_q) && (surf_cnt_q == surf_num_q);
    assign line_stride_ext = {{(AW-STW){1'b0}}, line_stride_q};
    assign surf_stride_ext = {{(AW-STW){1'b0}}, surf_stride_q};

    // DMA payload layout: {cube_end, odd, size, addr}; odd flags an odd beat count
    function automatic logic [DPW-1:0] pack_cmd(input logic [AW-1:0] addr,
                                                input logic [SW-1:0] size,
                                                input logic          cube_end);
        return {cube_end, ~size[0], size, addr};
    endfunction

    // State register and all registered outputs
    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state_q       <= IDLE;
            width_q       <= '0;
            height_q      <= '0;
            surf_num_q    <= '0;
            line_stride_q <= '0;
            surf_stride_q <= '0;
            line_cnt_q    <= '0;
            surf_cnt_q    <= '0;
            line_addr_q   <= '0;
            surf_addr_q   <= '0;
            dma_acc_q     <= 1'b0;
            spt_acc_q     <= 1'b0;
            dma_pvld_q    <= 1'b0;
            spt_pvld_q    <= 1'b0;
            dma_pd_q      <= '0;
            spt_pd_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            width_q       <= width_d;
            height_q      <= height_d;
            surf_num_q    <= surf_num_d;
            line_stride_q <= line_stride_d;
            surf_stride_q <= surf_stride_d;
            line_cnt_q    <= line_cnt_d;
            surf_cnt_q    <= surf_cnt_d;
            line_addr_q   <= line_addr_d;
            surf_addr_q   <= surf_addr_d;
            dma_acc_q     <= dma_acc_d;
            spt_acc_q     <= spt_acc_d;
            dma_pvld_q    <= dma_pvld_d;
            spt_pvld_q    <= spt_pvld_d;
            dma_pd_q      <= dma_pd_d;
            spt_pd_q      <= spt_pd_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    // Next-state: start a layer, track per-channel accepts, advance the walk
    always_comb begin
        state_d       = state_q;
        width_d       = width_q;
        height_d      = height_q;
        surf_num_d    = surf_num_q;
        line_stride_d = line_stride_q;
        surf_stride_d = surf_stride_q;
        line_cnt_d    = line_cnt_q;
        surf_cnt_d    = surf_cnt_q;
        line_addr_d   = line_addr_q;
        surf_addr_d   = surf_addr_q;
        dma_acc_d     = dma_acc_q;
        spt_acc_d     = spt_acc_q;
        dma_pvld_d    = dma_pvld_q;
        spt_pvld_d    = spt_pvld_q;
        dma_pd_d      = dma_pd_q;
        spt_pd_d      = spt_pd_q;
        busy_d        = busy_q;
        done_d        = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_load) begin
                    state_d       = RUN;
                    width_d       = reg2dp_width;
                    height_d      = reg2dp_height;
                    surf_num_d    = reg2dp_surf_num;
                    line_stride_d = reg2dp_dst_line_stride;
                    surf_stride_d = reg2dp_dst_surf_stride;
                    line_cnt_d    = '0;
                    surf_cnt_d    = '0;
                    line_addr_d   = reg2dp_dst_base_addr;
                    surf_addr_d   = reg2dp_dst_base_addr;
                    dma_acc_d     = 1'b0;
                    spt_acc_d     = 1'b0;
                    dma_pvld_d    = 1'b1;
                    spt_pvld_d    = 1'b1;
                    busy_d        = 1'b1;
                    dma_pd_d      = pack_cmd(reg2dp_dst_base_addr, reg2dp_width,
                                             (reg2dp_height == '0) && (reg2dp_surf_num == '0));
                    spt_pd_d      = dma_pd_d[DPW-1:AW];
                end
            end
            RUN: begin
                if (pair_done) begin
                    dma_acc_d = 1'b0;
                    spt_acc_d = 1'b0;
                    if (cur_cube_end) begin
                        state_d    = IDLE;
                        dma_pvld_d = 1'b0;
                        spt_pvld_d = 1'b0;
                        dma_pd_d   = '0;
                        spt_pd_d   = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        if (line_cnt_q == height_q) begin
                            // Next surface starts one surface stride past the current surface origin
                            line_cnt_d  = '0;
                            surf_cnt_d  = surf_cnt_q + 8'd1;
                            surf_addr_d = surf_addr_q + surf_stride_ext;
                            line_addr_d = surf_addr_q + surf_stride_ext;
                        end else begin
                            line_cnt_d  = line_cnt_q + 13'd1;
                            line_addr_d = line_addr_q + line_stride_ext;
                        end
                        dma_pvld_d = 1'b1;
                        spt_pvld_d = 1'b1;
                        dma_pd_d   = pack_cmd(line_addr_d, width_q,
                                              (line_cnt_d == height_q) && (surf_cnt_d == surf_num_q));
                        spt_pd_d   = dma_pd_d[DPW-1:AW];
                    end
                end else begin
                    // Hold payload; a channel that accepted waits for its partner
                    dma_acc_d  = dma_acc_q | dma_fire;
                    spt_acc_d  = spt_acc_q | spt_fire;
                    dma_pvld_d = dma_pvld_q & ~dma_fire;
                    spt_pvld_d = spt_pvld_q & ~spt_fire;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign cmd2dat_dma_pvld = dma_pvld_q;
    assign cmd2dat_spt_pvld = spt_pvld_q;
    assign cmd2dat_dma_pd   = dma_pd_q;
    assign cmd2dat_spt_pd   = spt_pd_q;
    assign cmd_busy         = busy_q;
    assign cmd_done         = done_q;

endmodule

// File: tb/tb_nvdla_sdp_wdma_cmd.sv
// Testbench for nvdla_sdp_wdma_cmd: a cube-walk model builds the expected
// command list at op_load; a negedge process checks both channels, busy and
// done against it every cycle.
module tb_nvdla_sdp_wdma_cmd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_load = 1'b0;
    logic [12:0] reg2dp_width = '0;
    logic [12:0] reg2dp_height = '0;
    logic [7:0]  reg2dp_surf_num = '0;
    logic [59:0] reg2dp_dst_base_addr = '0;
    logic [27:0] reg2dp_dst_line_stride = '0;
    logic [27:0] reg2dp_dst_surf_stride = '0;
    logic        dma_pvld;
    logic        dma_prdy = 1'b1;
    logic [74:0] dma_pd;
    logic        spt_pvld;
    logic        spt_prdy = 1'b1;
    logic [14:0] spt_pd;
    logic        cmd_busy;
    logic        cmd_done;

    always #5 clk = ~clk;

    nvdla_sdp_wdma_cmd dut (
        .nvdla_core_clk         (clk),
        .nvdla_core_rst         (rst),
        .op_load                (op_load),
        .reg2dp_width           (reg2dp_width),
        .reg2dp_height          (reg2dp_height),
        .reg2dp_surf_num        (reg2dp_surf_num),
        .reg2dp_dst_base_addr   (reg2dp_dst_base_addr),
        .reg2dp_dst_line_stride (reg2dp_dst_line_stride),
        .reg2dp_dst_surf_stride (reg2dp_dst_surf_stride),
        .cmd2dat_dma_pvld       (dma_pvld),
        .cmd2dat_dma_prdy       (dma_prdy),
        .cmd2dat_dma_pd         (dma_pd),
        .cmd2dat_spt_pvld       (spt_pvld),
        .cmd2dat_spt_prdy       (spt_prdy),
        .cmd2dat_spt_pd         (spt_pd),
        .cmd_busy               (cmd_busy),
        .cmd_done               (cmd_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_before = 0;

    // Model state
    logic [74:0] exp_cmd[$];
    logic [74:0] log_dma[$];
    int          log_cyc[$];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_dacc = 0;
    int          m_sacc = 0;
    int          m_total = 0;

    // 0: readys high, 1: random readys, 2: readys driven by the test
    int rdy_mode = 0;
    bit scramble = 1'b0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected command list: line l of surface s sits at base + s*surf_stride + l*line_stride
    task automatic model_load();
        longint unsigned a;
        int h;
        int sn;
        h  = int'(reg2dp_height);
        sn = int'(reg2dp_surf_num);
        exp_cmd.delete();
        for (int s = 0; s <= sn; s++) begin
            for (int l = 0; l <= h; l++) begin
                a = 64'(reg2dp_dst_base_addr) + 64'(s) * 64'(reg2dp_dst_line_stride * 0 + reg2dp_dst_surf_stride)
                  + 64'(l) * 64'(reg2dp_dst_line_stride);
                exp_cmd.push_back({(l == h) && (s == sn), ~reg2dp_width[0], reg2dp_width, a[59:0]});
            end
        end
        m_total = (h + 1) * (sn + 1);
        m_dacc  = 0;
        m_sacc  = 0;
        m_busy  = 1'b1;
    endtask

    logic [74:0] e_d;
    logic [74:0] e_s;
    bit          edv;
    bit          esv;
    int          pairs;

    // Per-cycle comparison against the model, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            chk("rst_dma_pvld", 80'(dma_pvld), 80'(0));
            chk("rst_spt_pvld", 80'(spt_pvld), 80'(0));
            chk("rst_busy", 80'(cmd_busy), 80'(0));
            chk("rst_done", 80'(cmd_done), 80'(0));
            chk("rst_dma_pd", 80'(dma_pd), 80'(0));
            chk("rst_spt_pd", 80'(spt_pd), 80'(0));
            m_busy = 1'b0;
            m_done = 1'b0;
            m_dacc = 0;
            m_sacc = 0;
            exp_cmd.delete();
        end else begin
            if (cmd_done) done_cnt++;
            pairs = (m_dacc < m_sacc) ? m_dacc : m_sacc;
            edv   = m_busy && (m_dacc == pairs);
            esv   = m_busy && (m_sacc == pairs);
            chk("dma_pvld", 80'(dma_pvld), 80'(edv));
            chk("spt_pvld", 80'(spt_pvld), 80'(esv));
            chk("busy", 80'(cmd_busy), 80'(m_busy));
            chk("done", 80'(cmd_done), 80'(m_done));
            if (edv && dma_pvld) begin
                e_d = exp_cmd[m_dacc];
                chk("dma_pd", 80'(dma_pd), 80'(e_d));
                if (dma_prdy) begin
                    log_dma.push_back(dma_pd);
                    log_cyc.push_back(cyc);
                    $display("dma cmd %0d: addr=%h size=%0d odd=%0b end=%0b", m_dacc,
                             dma_pd[59:0], dma_pd[72:60], dma_pd[73], dma_pd[74]);
                    m_dacc++;
                end
            end
            if (esv && spt_pvld) begin
                e_s = exp_cmd[m_sacc];
                chk("spt_pd", 80'(spt_pd), 80'(e_s[74:60]));
                if (spt_prdy) m_sacc++;
            end
            if (m_busy && m_dacc == m_total && m_sacc == m_total) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end else begin
                m_done = 1'b0;
                if (!m_busy && op_load) model_load();
            end
        end
    end

    // Ready generation and register scrambling while a layer runs
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            dma_prdy = 1'($urandom_range(0, 1));
            spt_prdy = 1'($urandom_range(0, 1));
        end else if (rdy_mode == 0) begin
            dma_prdy = 1'b1;
            spt_prdy = 1'b1;
        end
        if (scramble && m_busy) begin
            reg2dp_width           = 13'($urandom);
            reg2dp_height          = 13'($urandom);
            reg2dp_surf_num        = 8'($urandom);
            reg2dp_dst_base_addr   = 60'({$urandom, $urandom});
            reg2dp_dst_line_stride = 28'($urandom);
            reg2dp_dst_surf_stride = 28'($urandom);
        end
    end

    task automatic set_regs(input logic [12:0] w, input logic [12:0] h, input logic [7:0] sn,
                            input logic [59:0] base, input logic [27:0] ls, input logic [27:0] ss);
        reg2dp_width           = w;
        reg2dp_height          = h;
        reg2dp_surf_num        = sn;
        reg2dp_dst_base_addr   = base;
        reg2dp_dst_line_stride = ls;
        reg2dp_dst_surf_stride = ss;
    endtask

    task automatic pulse_load();
        @(posedge clk); #1;
        op_load = 1'b1;
        @(posedge clk); #1;
        op_load = 1'b0;
    endtask

    task automatic start_layer();
        log_dma.delete();
        log_cyc.delete();
        done_before = done_cnt;
        pulse_load();
    endtask

    task automatic finish_layer(input string name);
        int n;
        n = 0;
        while (done_cnt == done_before && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_timeout"}, 80'(n >= 3000), 80'(0));
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_done_count"}, 80'(done_cnt - done_before), 80'(1));
    endtask

    logic [59:0] basic_addr [4] = '{60'h100, 60'h110, 60'h140, 60'h150};
    logic [59:0] wrap_base = 60'hFFFFFFFFFFFFFF0;
    logic [74:0] held_pd;

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic cube, readys high
        rdy_mode = 0;
        scramble = 1'b0;
        set_regs(13'd3, 13'd1, 8'd1, 60'h100, 28'h10, 28'h40);
        start_layer();
        finish_layer("basic");
        chk("basic_count", 80'(log_dma.size()), 80'(4));
        for (int i = 0; i < 4 && i < log_dma.size(); i++) begin
            chk("basic_addr", 80'(log_dma[i][59:0]), 80'(basic_addr[i]));
            chk("basic_flags", 80'(log_dma[i][74:60]), 80'({i == 3, 1'b0, 13'd3}));
            chk("basic_consecutive", 80'(log_cyc[i] - log_cyc[0]), 80'(i));
        end

        // Skewed readys: split accepts at once, DMA held off for 5 cycles
        rdy_mode = 2;
        dma_prdy = 1'b0;
        spt_prdy = 1'b1;
        set_regs(13'd5, 13'd1, 8'd0, 60'h200, 28'h8, 28'h100);
        start_layer();
        @(posedge clk); #1;
        chk("skew_spt_dropped", 80'(spt_pvld), 80'(0));
        chk("skew_dma_held", 80'(dma_pvld), 80'(1));
        held_pd = dma_pd;
        repeat (3) begin
            @(posedge clk); #1;
            chk("skew_dma_stable", 80'(dma_pd), 80'(held_pd));
        end
        dma_prdy = 1'b1;
        finish_layer("skew");
        chk("skew_count", 80'(log_dma.size()), 80'(2));
        if (log_dma.size() > 1) chk("skew_addr1", 80'(log_dma[1][59:0]), 80'(60'h208));

        // Random backpressure, 8 lines x 4 surfaces
        rdy_mode = 1;
        scramble = 1'b1;
        set_regs(13'($urandom), 13'd7, 8'd3, 60'({$urandom, $urandom}),
                 28'($urandom), 28'($urandom));
        start_layer();
        finish_layer("rand32");
        chk("rand32_count", 80'(log_dma.size()), 80'(32));

        // Single line at the top of the address space, then a wrapping second line
        rdy_mode = 0;
        set_regs(13'd0, 13'd0, 8'd0, wrap_base, 28'h10, 28'h10);
        start_layer();
        finish_layer("single");
        chk("single_count", 80'(log_dma.size()), 80'(1));
        if (log_dma.size() > 0) chk("single_cmd", 80'(log_dma[0]), 80'({1'b1, 1'b1, 13'd0, wrap_base}));
        set_regs(13'd0, 13'd1, 8'd0, wrap_base, 28'h20, 28'h0);
        start_layer();
        finish_layer("wrap");
        if (log_dma.size() > 1) chk("wrap_addr", 80'(log_dma[1][59:0]), 80'(60'h10));

        // Assorted random layers
        rdy_mode = 1;
        for (int k = 0; k < 4; k++) begin
            set_regs(13'($urandom), 13'($urandom_range(0, 5)), 8'($urandom_range(0, 3)),
                     60'({$urandom, $urandom}), 28'($urandom), 28'($urandom));
            start_layer();
            finish_layer("rand_layer");
        end

        // Reload mid-RUN is ignored; reset mid-RUN aborts
        set_regs(13'd1, 13'd7, 8'd3, 60'h4000, 28'h10, 28'h100);
        start_layer();
        repeat (6) @(posedge clk);
        pulse_load();
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 80'(cmd_busy), 80'(0));
        chk("abort_dma_pvld", 80'(dma_pvld), 80'(0));
        chk("abort_spt_pvld", 80'(spt_pvld), 80'(0));
        chk("abort_dma_pd", 80'(dma_pd), 80'(0));
        chk("abort_done_count", 80'(done_cnt - done_before), 80'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        set_regs(13'd2, 13'd1, 8'd1, 60'h300, 28'h4, 28'h20);
        start_layer();
        finish_layer("restart");
        chk("restart_count", 80'(log_dma.size()), 80'(4));
        if (log_dma.size() > 0) chk("restart_addr0", 80'(log_dma[0][59:0]), 80'(60'h300));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
